// File: rtl/md_pkg.sv
// md_pkg: op-code and FSM state encodings shared by md_unit and its users.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package md_pkg;

  // Counter must hold the largest legal cycle count (63).
  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
// Latency: MULT* commits after MULT_CYCLES edges, DIV* after DIV_CYCLES, MTHI/MTLO after one edge.
// Backpressure: none; starts while busy are dropped, md_hazard (start|busy) tells the stall logic.
// Ports: clk, reset (sync, active-low), start/op/A/B request, busy, md_hazard, HI, LO.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             md_hazard,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  md_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_load;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_wr;

  logic is_mul, is_div, launch, done, mthi_req, mtlo_req;

  assign is_mul   = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div   = (op == OP_DIV)  || (op == OP_DIVU);
  assign launch   = start && (state == ST_IDLE) && (is_mul || is_div);
  assign done     = (state == ST_RUN) && (cnt == '0);
  assign mthi_req = start && (state == ST_IDLE) && (op == OP_MTHI);
  assign mtlo_req = start && (state == ST_IDLE) && (op == OP_MTLO);
  // Counter holds remaining edges minus one, so busy spans exactly N edges.
  assign cnt_load = is_mul ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);

  // Arithmetic is evaluated on the live operands and captured at the start edge,
  // which is what makes later operand changes irrelevant.
  logic [2*WIDTH-1:0] prod;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, div_q, div_r;

  always_comb begin
    if (op == OP_MULT)
      prod = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
    else
      prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    // Signed divide via magnitudes: |min| = 2^(W-1) still fits unsigned, so
    // min / -1 naturally yields min with a zero remainder.
    a_neg  = (op == OP_DIV) && A[WIDTH-1];
    b_neg  = (op == OP_DIV) && B[WIDTH-1];
    a_mag  = a_neg ? -A : A;
    b_mag  = b_neg ? -B : B;
    b_safe = (B == '0) ? WIDTH'(1) : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    div_q  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    div_r  = a_neg ? -r_mag : r_mag;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // FSM: next state
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (launch) state_n = ST_RUN;
      ST_RUN:  if (cnt == '0) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state == ST_RUN);
    md_hazard = start | busy;
  end

  // Counter, result capture and HI/LO commit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_wr <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      if (launch) begin
        cnt    <= cnt_load;
        res_hi <= is_mul ? prod[2*WIDTH-1:WIDTH] : div_r;
        res_lo <= is_mul ? prod[WIDTH-1:0]       : div_q;
        // A divide by zero still occupies the unit but leaves HI/LO alone.
        res_wr <= is_mul || (B != '0);
      end else if ((state == ST_RUN) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      if (done && res_wr) begin
        HI <= res_hi;
        LO <= res_lo;
      end else begin
        if (mthi_req) HI <= A;
        if (mtlo_req) LO <= A;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  import md_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] A, B;
  logic         busy, md_hazard;
  logic [W-1:0] HI, LO;

  int vectors     = 0;
  int miscompares = 0;

  // Reference architectural state.
  logic [W-1:0] m_hi, m_lo;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .md_hazard(md_hazard), .HI(HI), .LO(LO)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int op_cycles(input logic [2:0] o);
    case (o)
      OP_MULT, OP_MULTU: return MC;
      OP_DIV, OP_DIVU:   return DC;
      default:           return 0;
    endcase
  endfunction

  // Architectural effect of one accepted instruction, from plain 64-bit math.
  task automatic model_apply(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      OP_DIV:   if (b != 0) begin m_lo = W'(sa / sb); m_hi = W'(sa % sb); end
      OP_DIVU:  if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      OP_MTHI:  m_hi = a;
      OP_MTLO:  m_lo = a;
      default:  ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction from idle and follow it to completion.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] old_hi, old_lo;
    int n;
    old_hi = m_hi; old_lo = m_lo; n = op_cycles(o);
    op = o; A = a; B = b; start = 1'b1;
    #1;
    vectors++;
    if (md_hazard !== 1'b1) begin
      miscompares++; $display("FAIL %s hazard_on_start: got %b want 1", tag, md_hazard);
    end
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom; op = 3'($urandom);
    model_apply(o, a, b);
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (busy !== 1'b1 || md_hazard !== 1'b1) begin
        miscompares++; $display("FAIL %s busy_cycle%0d: got busy=%b hz=%b want 1/1", tag, i, busy, md_hazard);
      end
      vectors++;
      if (HI !== old_hi || LO !== old_lo) begin
        miscompares++; $display("FAIL %s hold_cycle%0d: got %h_%h want %h_%h", tag, i, HI, LO, old_hi, old_lo);
      end
      tick();
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL %s busy_done: got %b want 0", tag, busy);
    end
    vectors++;
    if (HI !== m_hi || LO !== m_lo) begin
      miscompares++; $display("FAIL %s result: got %h_%h want %h_%h", tag, HI, LO, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = OP_MULT; A = '0; B = '0;
    repeat (2) tick();
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    vectors++;
    if (busy !== 1'b0 || md_hazard !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got busy=%b hz=%b want 0/0", busy, md_hazard);
    end
    vectors++;
    if (HI !== '0 || LO !== '0) begin
      miscompares++; $display("FAIL reset_hilo: got %h_%h want 0_0", HI, LO);
    end
  endtask

  task automatic test_scenarios();
    run_op("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7);
    vectors++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFEB) begin
      miscompares++; $display("FAIL mult_const: got %h_%h want ffffffff_ffffffeb", HI, LO);
    end
    run_op("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    vectors++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
      miscompares++; $display("FAIL div_const: got %h_%h want ffffffff_fffffffd", HI, LO);
    end
    run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h10);
    vectors++;
    if (HI !== 32'hF || LO !== 32'h0FFF_FFFF) begin
      miscompares++; $display("FAIL divu_const: got %h_%h want 0000000f_0fffffff", HI, LO);
    end
    run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    vectors++;
    if (HI !== 32'h0 || LO !== 32'h8000_0000) begin
      miscompares++; $display("FAIL div_min_const: got %h_%h want 00000000_80000000", HI, LO);
    end
  endtask

  task automatic test_div_zero();
    run_op("mthi", OP_MTHI, 32'h11, 32'h0);
    run_op("mtlo", OP_MTLO, 32'h22, 32'h0);
    run_op("div_by0", OP_DIV, 32'h1234, 32'h0);
    vectors++;
    if (HI !== 32'h11 || LO !== 32'h22) begin
      miscompares++; $display("FAIL div0_const: got %h_%h want 00000011_00000022", HI, LO);
    end
    run_op("divu_by0", OP_DIVU, 32'hFFFF, 32'h0);
  endtask

  task automatic test_busy_ignore();
    // MTLO issued on the second busy cycle must be dropped.
    op = OP_MULTU; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    op = OP_MTLO; A = 32'h5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (MC - 2) tick();
    m_hi = 32'hFFFF_FFFE; m_lo = 32'h1;
    vectors++;
    if (busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
      miscompares++; $display("FAIL busy_ignore: got busy=%b %h_%h want 0 fffffffe_00000001", busy, HI, LO);
    end
    // A start landing on the completion edge is also dropped.
    for (int k = 0; k < 2; k++) begin
      op = OP_MULT; A = 32'd2; B = 32'd3; start = 1'b1;
      tick();
      A = 32'hDEAD; op = (k == 0) ? OP_MTHI : OP_MULTU; start = 1'b0;
      repeat (MC - 1) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      m_hi = 32'h0; m_lo = 32'h6;
      vectors++;
      if (busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
        miscompares++; $display("FAIL done_edge_start%0d: got busy=%b %h_%h want 0 00000000_00000006", k, busy, HI, LO);
      end
      tick();
      vectors++;
      if (busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
        miscompares++; $display("FAIL done_edge_after%0d: got busy=%b %h_%h want 0 00000000_00000006", k, busy, HI, LO);
      end
    end
  endtask

  task automatic test_undefined_op();
    run_op("mthi_pre", OP_MTHI, 32'hA5A5_0001, 32'h0);
    run_op("undef6", 3'd6, 32'h1111, 32'h2222);
    run_op("undef7", 3'd7, 32'h3333, 32'h4444);
  endtask

  task automatic test_reset_abort();
    op = OP_MULT; A = 32'd1234; B = 32'd5678; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    vectors++;
    if (busy !== 1'b0 || HI !== '0 || LO !== '0) begin
      miscompares++; $display("FAIL abort_now: got busy=%b %h_%h want 0 0_0", busy, HI, LO);
    end
    repeat (MC + 2) tick();
    vectors++;
    if (busy !== 1'b0 || HI !== '0 || LO !== '0) begin
      miscompares++; $display("FAIL abort_later: got busy=%b %h_%h want 0 0_0", busy, HI, LO);
    end
    // Reset wins over a simultaneous start.
    op = OP_MULT; A = 32'd9; B = 32'd9; start = 1'b1; reset = 1'b0;
    tick();
    start = 1'b0; reset = 1'b1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_prio_busy: got %b want 0", busy);
    end
    op = OP_MTHI; A = 32'h77; start = 1'b1; reset = 1'b0;
    tick();
    start = 1'b0; reset = 1'b1;
    vectors++;
    if (HI !== '0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_prio_mthi: got busy=%b HI=%h want 0 0", busy, HI);
    end
  endtask

  task automatic test_random();
    logic [2:0]   o;
    logic [W-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op($sformatf("rand%0d_op%0d", i, o), o, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_scenarios();
    test_div_zero();
    test_busy_ignore();
    test_undefined_op();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
